// File: rtl/vga_capture8_pkg.sv
// Shared VGA 640x480@60 timing defaults, lock FSM state type and window helper.
// Used by the capture block and by any timing generator that must agree with it.
package vga_capture8_pkg;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_START  = 48;
    localparam int VGA_V_START  = 33;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    function automatic logic in_window(input logic [9:0] cnt, input int start, input int len);
        return ({1'b0, cnt} >= 11'(start)) && ({1'b0, cnt} < 11'(start + len));
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input and flags its low-to-high transition.
// The register resets high so a sync held high through reset is not seen as a rise.
module vga_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic rise
);

    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= sync;
        end
    end

    assign rise = sync & ~sync_q;

endmodule

// File: rtl/vga_capture8.sv
// VGA frame grabber: measures hs/vs timing, locks after one clean frame and
// writes each active pixel of an enabled frame to an external RAM port.
module vga_capture8
    import vga_capture8_pkg::*;
#(
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int H_START  = VGA_H_START,
    parameter int V_START  = VGA_V_START,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic        hs,
    input  logic        vs,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        cap_en,
    output logic        wrn,
    output logic [8:0]  wr_row,
    output logic [9:0]  wr_col,
    output logic [23:0] wr_data,
    output logic        frame_done,
    output logic        locked,
    output logic        err
);

    // state     | meaning
    // UNLOCKED  | timing unknown or just broken; wait for a vs rise
    // ARMED     | measuring one full frame; any mismatch drops back
    // LOCKED    | timing trusted; capture per frame follows cap_en

    lock_state_t state, state_next;
    logic        hs_rise, vs_rise;
    logic [9:0]  h_cnt, v_cnt;
    logic        h_bad, v_bad, mismatch;
    logic        capture, capture_next;
    logic        pix_active, wr_en;

    vga_sync_edge u_hs_edge (.clk(vga_clk), .rst_n(clrn), .sync(hs), .rise(hs_rise));
    vga_sync_edge u_vs_edge (.clk(vga_clk), .rst_n(clrn), .sync(vs), .rise(vs_rise));

    // vs reload has priority so a coincident hs rise leaves v_cnt at 0
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hs_rise) begin
                h_cnt <= '0;
            end else if (h_cnt != 10'h3FF) begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (vs_rise) begin
                v_cnt <= '0;
            end else if (hs_rise && (v_cnt != 10'h3FF)) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    assign h_bad      = hs_rise && (({1'b0, h_cnt} + 11'd1) != 11'(H_TOTAL));
    assign v_bad      = vs_rise && (({1'b0, v_cnt} + 11'd1) != 11'(V_TOTAL));
    assign mismatch   = h_bad || v_bad;
    assign pix_active = in_window(v_cnt, V_START, V_ACTIVE) && in_window(h_cnt, H_START, H_ACTIVE);

    always_comb begin
        state_next   = state;
        capture_next = capture;
        wr_en        = 1'b0;
        case (state)
            ST_UNLOCKED: if (vs_rise) state_next = ST_ARMED;
            ST_ARMED: begin
                if (mismatch) begin
                    state_next = ST_UNLOCKED;
                end else if (vs_rise) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_LOCKED:   if (mismatch) state_next = ST_UNLOCKED;
            default:     state_next = ST_UNLOCKED;
        endcase
        if (state_next != ST_LOCKED) begin
            capture_next = 1'b0;
        end else if (vs_rise) begin
            capture_next = cap_en;
        end
        wr_en = capture && pix_active && !mismatch;
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state   <= ST_UNLOCKED;
            capture <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            capture <= capture_next;
            err     <= err | ((state == ST_LOCKED) && mismatch);
        end
    end

    // frame_done fires on the edge after the bottom-right pixel's write strobe
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            wrn        <= 1'b1;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wrn        <= ~wr_en;
            frame_done <= ~wrn && (wr_row == 9'(V_ACTIVE - 1)) && (wr_col == 10'(H_ACTIVE - 1));
            if (wr_en) begin
                wr_row  <= 9'(v_cnt - 10'(V_START));
                wr_col  <= h_cnt - 10'(H_START);
                wr_data <= {r, g, b};
            end
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_vga_capture8.sv
// Scoreboard bench for vga_capture8 on a scaled-down video mode: a generator
// drives sync and pixel pattern, expected writes are queued and popped per strobe.
module tb_vga_capture8;
    import vga_capture8_pkg::*;

    localparam int HT  = 24;
    localparam int VT  = 14;
    localparam int HS0 = 4;
    localparam int VS0 = 3;
    localparam int HA  = 16;
    localparam int VA  = 8;
    localparam int NPIX = HA * VA;

    logic        vga_clk = 1'b0;
    logic        clrn    = 1'b0;
    logic        hs      = 1'b1;
    logic        vs      = 1'b1;
    logic        cap_en  = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        wrn, frame_done, locked, err;
    logic [8:0]  wr_row;
    logic [9:0]  wr_col;
    logic [23:0] wr_data;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr, n_done;
    logic done_due = 1'b0;
    logic [42:0] exp_q[$];

    vga_capture8 #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS0), .V_START(VS0),
        .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .vga_clk(vga_clk), .clrn(clrn), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .cap_en(cap_en), .wrn(wrn), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .frame_done(frame_done), .locked(locked), .err(err)
    );

    always #20 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        logic [42:0] e;
        if (frame_done) n_done++;
        if (done_due) begin
            chk("frame_done", 64'(frame_done), 64'd1);
            done_due = 1'b0;
        end else if (frame_done) begin
            chk("frame_done_spurious", 64'(frame_done), 64'd0);
        end
        if (!wrn) n_wr++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wrn", 64'(wrn), 64'd0);
            chk("wr_fields", 64'({wr_row, wr_col, wr_data}), 64'(e));
            if (e[42:24] == {9'(VA - 1), 10'(HA - 1)}) done_due = 1'b1;
        end else if (!wrn) begin
            chk("wr_spurious", 64'({wrn, wr_row, wr_col}), {45'd0, 1'b1, wr_row, wr_col});
        end
    endtask

    task automatic drive(input int x, input int y, input bit exp_cap);
        int sx, sy;
        sx = (x + 1) % HT;
        sy = (x == HT - 1) ? (y + 1) % VT : y;
        hs = (sx < HT - 2);
        vs = (sy < VT - 2);
        r  = 8'(y - VS0);
        g  = 8'(x - HS0);
        b  = 8'h5A;
        if (exp_cap && x >= HS0 && x < HS0 + HA && y >= VS0 && y < VS0 + VA)
            exp_q.push_back({9'(y - VS0), 10'(x - HS0), 8'(y - VS0), 8'(x - HS0), 8'h5A});
    endtask

    // bad_gy: that line is one clock short; rst_gy: assert clrn at the start of that line
    task automatic run_frame(input bit exp_cap, input bit cap_a, input bit cap_b,
                             input int bad_gy, input int rst_gy);
        n_wr   = 0;
        n_done = 0;
        for (int y = 0; y < VT; y++) begin
            for (int x = (y == bad_gy) ? 1 : 0; x < HT; x++) begin
                @(negedge vga_clk);
                sample();
                if (y == bad_gy && x == HT - 1) chk("pre_bad_lock_err", 64'({locked, err}), 64'b10);
                if (bad_gy >= 0 && y == bad_gy + 1 && x == 0)
                    chk("post_bad_lock_err", 64'({locked, err}), 64'b01);
                if (y == rst_gy && x == 0) begin
                    clrn = 1'b0;
                    #1;
                    chk("async_reset_out",
                        64'({wrn, wr_row, wr_col, wr_data, frame_done, locked, err}),
                        {17'd0, 1'b1, 46'd0});
                    chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);
                    return;
                end
                cap_en = (y < VT / 2) ? cap_a : cap_b;
                drive(x, y, exp_cap);
            end
        end
        chk("frame_writes", 64'(n_wr), exp_cap ? 64'(NPIX) : 64'd0);
        chk("frame_done_pulses", 64'(n_done), exp_cap ? 64'd1 : 64'd0);
    endtask

    task automatic check_after_vs(input string tag, input bit exp_locked, input bit exp_err);
        @(posedge vga_clk);
        #1;
        chk(tag, 64'({locked, err}), 64'({exp_locked, exp_err}));
    endtask

    initial begin
        repeat (3) @(negedge vga_clk);
        #1;
        chk("reset_state", 64'({wrn, wr_row, wr_col, wr_data, frame_done, locked, err}),
            {17'd0, 1'b1, 46'd0});
        @(negedge vga_clk);
        clrn = 1'b1;

        // lock-up: two frames to lock, third frame captured
        run_frame(1'b0, 1'b1, 1'b1, -1, -1);
        check_after_vs("lock_vs1", 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b1, -1, -1);
        check_after_vs("lock_vs2", 1'b1, 1'b0);
        run_frame(1'b1, 1'b1, 1'b1, -1, -1);
        check_after_vs("frame3_end", 1'b1, 1'b0);

        // cap_en drops mid-frame: this frame completes, next one is skipped
        run_frame(1'b1, 1'b1, 1'b0, -1, -1);
        run_frame(1'b0, 1'b0, 1'b1, -1, -1);
        run_frame(1'b1, 1'b1, 1'b1, -1, -1);

        // short line while locked: unlock, sticky err, relock after two frames
        run_frame(1'b0, 1'b1, 1'b1, 1, -1);
        check_after_vs("bad_frame_end", 1'b0, 1'b1);
        run_frame(1'b0, 1'b1, 1'b1, -1, -1);
        check_after_vs("relock_vs2", 1'b1, 1'b1);
        run_frame(1'b1, 1'b1, 1'b1, -1, -1);
        check_after_vs("err_sticky", 1'b1, 1'b1);

        // reset in the middle of a captured frame
        run_frame(1'b1, 1'b1, 1'b1, -1, VS0 + 5);
        repeat (3) @(negedge vga_clk);
        clrn = 1'b1;
        run_frame(1'b0, 1'b1, 1'b1, -1, -1);
        check_after_vs("rst_relock_vs1", 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b1, -1, -1);
        check_after_vs("rst_relock_vs2", 1'b1, 1'b0);
        run_frame(1'b1, 1'b1, 1'b1, -1, -1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_capture8.md
VGA_CAPTURE8 -- requirements
Module: vga_capture8

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning:
 H_TOTAL 800 clocks per line; V_TOTAL 525 lines per frame; H_START 48 clocks from hs rise to pixel 0; V_START 33 lines from vs rise to row 0; H_ACTIVE 640; V_ACTIVE 480.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, ports (name direction width meaning):
 vga_clk in 1 pixel clock, 25 MHz, all logic on rising edge
 clrn in 1 asynchronous active-low reset
 hs in 1 horizontal sync, low during sync pulse
 vs in 1 vertical sync, low during sync pulse
 r, g, b in 8 each pixel colour
 cap_en in 1 capture enable, sampled only at frame start
 wrn out 1 pixel RAM write strobe, active low
 wr_row out 9 pixel RAM row address 0-479
 wr_col out 10 pixel RAM column address 0-639
 wr_data out 24 {r,g,b}
 frame_done out 1 one-cycle pulse after last pixel of a captured frame
 locked out 1 timing lock indicator
 err out 1 sticky timing error, cleared only by reset

Function
REQ-003 hs and vs SHALL be registered once (hs_q, vs_q); a rise is hs_q=0 with hs=1 at the same edge.
REQ-004 h_cnt (10 bit) SHALL load 0 on each hs rise and otherwise increment, saturating at 1023.
REQ-005 v_cnt (10 bit) SHALL load 0 on each vs rise and otherwise increment on each hs rise, saturating at 1023.
REQ-006 At each hs rise, line length h_cnt+1 SHALL be compared with H_TOTAL; at each vs rise, line count v_cnt+1 SHALL be compared with V_TOTAL.
REQ-007 FSM states: UNLOCKED, ARMED, LOCKED. UNLOCKED->ARMED on a vs rise. ARMED->LOCKED on the next vs rise if every line and the frame count matched. ARMED->UNLOCKED on any mismatch.
REQ-008 In LOCKED, any mismatch SHALL force UNLOCKED, set err, and abort capture of the current frame.
REQ-009 locked SHALL be 1 only in LOCKED.
REQ-010 On each vs rise in LOCKED (including the ARMED->LOCKED edge), capture for that frame SHALL equal cap_en; changes mid-frame have no effect.
REQ-011 A pixel is active when V_START <= v_cnt < V_START+V_ACTIVE and H_START <= h_cnt < H_START+H_ACTIVE.
REQ-012 For an active pixel in a capturing frame, the next edge SHALL drive wrn=0, wr_row=v_cnt-V_START, wr_col=h_cnt-H_START and wr_data={r,g,b} as sampled with that h_cnt; latency is exactly 1 clock.
REQ-013 wrn SHALL be 1 at all other times; wr_row, wr_col and wr_data hold their last values.
REQ-014 frame_done SHALL pulse high for exactly 1 clock, on the edge after the write of row 479, column 639.
REQ-015 An hs rise mid-active-line SHALL restart h_cnt; writes in progress stop, and the mismatch rule in REQ-008 applies.
REQ-016 Simultaneous hs and vs rises SHALL apply both the h_cnt and v_cnt reloads, with v_cnt=0.

Reset
REQ-017 While clrn=0, the block SHALL set: state UNLOCKED, h_cnt=0, v_cnt=0, hs_q=1, vs_q=1, wrn=1, wr_row=0, wr_col=0, wr_data=0, frame_done=0, locked=0, err=0, capture=0.
REQ-018 Reset during a frame SHALL abandon it; relock SHALL require two full vs-to-vs frames.

Structure
REQ-019 Timing defaults (800/525/48/33/640/480) SHALL live in a shared VGA timing package, also used by the generator.
REQ-020 One sub-module, vga_sync_edge, SHALL hold the sync register and rise detection; it is instantiated once for hs and once for vs.

Verification
REQ-021 The bench SHALL cover these scenarios:
 Standard timing for 3 frames, cap_en=1 -> locked rises at the 2nd vs rise; 307200 writes in frame 3; 1 frame_done pulse; err=0.
 Pixel value r=row[7:0], g=col[7:0], b=0x5A -> every write satisfies wr_data=={wr_row[7:0], wr_col[7:0], 8'h5A}; first write is row 0, col 0.
 One line of length 799 in a locked frame -> locked=0 and err=1 within 1 clock of that hs rise; no writes until relock.
 cap_en toggled 1->0 mid-frame -> frame completes fully; next frame has zero writes.
 clrn asserted at row 200 -> all outputs take reset values immediately; relock after 2 frames.
 Boundary pixels (row 479, col 639) -> written; no write at h_cnt=H_START-1 or H_START+640.
